// File: rtl/lamp_fpu_f2i_seq_if.sv
// Operand/result handshake bundle for the bf16-to-int converter.
// Upstream side: valid_i/ready_o with op_i and rm_i; downstream side: valid_o/ready_i with result and flags.
// The converter uses the slave modport, the driver of operands and consumer of results uses master.
interface lamp_fpu_f2i_seq_if #(
  parameter int INT_DW = 32,
  parameter int OP_DW  = 16
);
  logic              valid_i;
  logic              ready_o;
  logic [OP_DW-1:0]  op_i;
  logic              rm_i;
  logic              valid_o;
  logic              ready_i;
  logic [INT_DW-1:0] result_o;
  logic              invalid_o;
  logic              inexact_o;

  modport slave (
    input  valid_i, op_i, rm_i, ready_i,
    output ready_o, valid_o, result_o, invalid_o, inexact_o
  );

  modport master (
    output valid_i, op_i, rm_i, ready_i,
    input  ready_o, valid_o, result_o, invalid_o, inexact_o
  );
endinterface

// File: rtl/lamp_fpu_f2i_seq.sv
// Sequential bf16 -> signed int converter using a 1-bit-per-cycle normalising shifter, RTZ/RNE rounding.
// Latency: specials 1 cycle to valid_o, normal path |E-7|+2 cycles (2..25 for the default widths).
// Backpressure: one operand in flight; ready_o only in IDLE, result and flags held until ready_i.
module lamp_fpu_f2i_seq #(
  parameter int INT_DW = 32,
  parameter int E_DW   = 8,
  parameter int F_DW   = 7,
  parameter int E_BIAS = 127
) (
  input logic               clk,
  input logic               rst_n,
  lamp_fpu_f2i_seq_if.slave bus
);

  localparam int CNT_DW = $clog2(INT_DW);
  // Largest unbiased exponent that still fits, and the exponent at which m needs no shift.
  localparam logic signed [E_DW:0] E_MAX   = (E_DW+1)'(INT_DW-1);
  localparam logic signed [E_DW:0] E_ALIGN = (E_DW+1)'(F_DW);
  localparam logic signed [E_DW:0] E_HALF  = '1;
  localparam logic [INT_DW-1:0]    MAX_INT = {1'b0, {(INT_DW-1){1'b1}}};
  localparam logic [INT_DW-1:0]    MIN_INT = {1'b1, {(INT_DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t state, nextState;

  logic                   opS;
  logic [E_DW-1:0]        opE;
  logic [F_DW-1:0]        opF;
  logic signed [E_DW:0]   expUnb;
  logic                   shiftLeft;
  logic [CNT_DW-1:0]      cntLoad;

  logic                   isSpecial;
  logic [INT_DW-1:0]      spRes;
  logic                   spInv;
  logic                   spInx;

  logic [INT_DW-1:0]      work;
  logic                   guardQ;
  logic                   stickyQ;
  logic                   signQ;
  logic                   rmQ;
  logic                   leftQ;
  logic [CNT_DW-1:0]      cnt;
  logic [INT_DW-1:0]      resultQ;
  logic                   invalidQ;
  logic                   inexactQ;
  logic                   validQ;

  logic                   readyO;
  logic                   accept;
  logic                   deliver;
  logic                   roundUp;
  logic [INT_DW-1:0]      rounded;

  assign {opS, opE, opF} = bus.op_i;
  assign expUnb    = $signed({1'b0, opE}) - $signed((E_DW+1)'(E_BIAS));
  assign shiftLeft = (expUnb >= E_ALIGN);
  assign cntLoad   = CNT_DW'(shiftLeft ? (expUnb - E_ALIGN) : (E_ALIGN - expUnb));

  // Classify the incoming operand and form the one-cycle result for everything off the shifter path.
  always_comb begin
    isSpecial = 1'b1;
    spRes     = '0;
    spInv     = 1'b0;
    spInx     = 1'b0;
    if (opE == '1) begin
      spInv = 1'b1;
      spRes = (opF == '0 && opS) ? MIN_INT : MAX_INT;
    end else if (opE == '0) begin
      spInx = (opF != '0);
    end else if (expUnb[E_DW]) begin
      // |x| < 1: only (0.5,1) under RNE rounds away from zero.
      spInx = 1'b1;
      if (bus.rm_i && expUnb == E_HALF && opF != '0) begin
        spRes = opS ? '1 : INT_DW'(1);
      end
    end else if (expUnb >= E_MAX) begin
      // -2^INT_DW-1 is the single representable value in this range.
      if (opS && expUnb == E_MAX && opF == '0) begin
        spRes = MIN_INT;
      end else begin
        spInv = 1'b1;
        spRes = opS ? MIN_INT : MAX_INT;
      end
    end else begin
      isSpecial = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state selection.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (isSpecial)          nextState = DONE;
          else if (cntLoad == '0) nextState = ROUND;
          else                    nextState = SHIFT;
        end
      end
      SHIFT:   if (cnt == CNT_DW'(1)) nextState = ROUND;
      ROUND:   nextState = DONE;
      DONE:    if (deliver) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake decode from the current state.
  always_comb begin
    readyO  = (state == IDLE);
    accept  = readyO && bus.valid_i;
    deliver = validQ && bus.ready_i;
  end

  assign roundUp = rmQ && guardQ && (stickyQ || work[0]);
  assign rounded = work + INT_DW'(roundUp);

  // Datapath: capture on accept, shift while in SHIFT, round and sign in ROUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      guardQ   <= 1'b0;
      stickyQ  <= 1'b0;
      signQ    <= 1'b0;
      rmQ      <= 1'b0;
      leftQ    <= 1'b0;
      cnt      <= '0;
      resultQ  <= '0;
      invalidQ <= 1'b0;
      inexactQ <= 1'b0;
    end else if (accept) begin
      work    <= INT_DW'({1'b1, opF});
      guardQ  <= 1'b0;
      stickyQ <= 1'b0;
      signQ   <= opS;
      rmQ     <= bus.rm_i;
      leftQ   <= shiftLeft;
      cnt     <= cntLoad;
      if (isSpecial) begin
        resultQ  <= spRes;
        invalidQ <= spInv;
        inexactQ <= spInx;
      end
    end else if (state == SHIFT) begin
      cnt <= cnt - 1'b1;
      if (leftQ) begin
        work <= work << 1;
      end else begin
        work    <= work >> 1;
        guardQ  <= work[0];
        stickyQ <= stickyQ | guardQ;
      end
    end else if (state == ROUND) begin
      resultQ  <= signQ ? -rounded : rounded;
      invalidQ <= 1'b0;
      inexactQ <= guardQ | stickyQ;
    end
  end

  // valid_o rises the cycle after DONE is entered and drops on the output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= 1'b0;
    end else if (state == DONE && !validQ) begin
      validQ <= 1'b1;
    end else if (deliver) begin
      validQ <= 1'b0;
    end
  end

  assign bus.ready_o   = readyO;
  assign bus.valid_o   = validQ;
  assign bus.result_o  = resultQ;
  assign bus.invalid_o = invalidQ;
  assign bus.inexact_o = inexactQ;

endmodule

// File: tb/tb_lamp_fpu_f2i_seq.sv
// Bench for lamp_fpu_f2i_seq: directed vector table, handshake/reset sequences, random ops vs value model.
// Latency is counted in edges from the acceptance edge to the first edge after which valid_o is seen high.
// Downstream stalls are inserted with ready_i low for a few cycles.
module tb_lamp_fpu_f2i_seq;

  logic clk;
  logic rst_n;

  lamp_fpu_f2i_seq_if #(.INT_DW(32), .OP_DW(16)) bus ();

  lamp_fpu_f2i_seq #(
    .INT_DW(32), .E_DW(8), .F_DW(7), .E_BIAS(127)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChk = 0;
  int nErr = 0;

  typedef struct {
    logic [15:0] op;
    logic        rm;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Value-level reference: x = (-1)^s * (128+f) * 2^(e-134), rounded to an integer, then range-checked.
  function automatic void model(input logic [15:0] op, input logic rm,
                                output logic [31:0] res, output logic inv,
                                output logic inx, output int lat);
    logic   s;
    int     e, f, p, sh;
    longint mant, mag, q, rem, half, val;
    bit     ovf;
    s = op[15];
    e = int'(op[14:7]);
    f = int'(op[6:0]);
    res = 32'h0; inv = 1'b0; inx = 1'b0; lat = 1; ovf = 1'b0;
    if (e == 255) begin
      inv = 1'b1;
      res = (f == 0 && s) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e == 0) begin
      inx = (f != 0);
    end else begin
      mant = longint'(128 + f);
      p = e - 134;
      mag = 0;
      if (p >= 0) begin
        if (p > 32) ovf = 1'b1;
        else mag = mant << p;
      end else begin
        sh = -p;
        if (sh > 20) begin
          q = 0; rem = mant; half = longint'(1) << 20;
        end else begin
          q = mant >> sh;
          rem = mant - (q << sh);
          half = longint'(1) << (sh - 1);
        end
        inx = (rem != 0);
        mag = q;
        if (rm && (rem > half || (rem == half && q[0]))) mag = q + 1;
      end
      val = s ? -mag : mag;
      if (ovf || val > 64'sd2147483647 || val < -64'sd2147483648) begin
        inv = 1'b1;
        inx = 1'b0;
        res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        res = val[31:0];
      end
      if (e >= 127 && e <= 157) lat = ((e >= 134) ? (e - 134) : (134 - e)) + 2;
    end
  endfunction

  // One complete transaction; hold = cycles ready_i stays low after valid_o appears.
  task automatic run(input logic [15:0] op, input logic rm, input int hold,
                     output logic [31:0] res, output logic inv, output logic inx, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready_o) chk("ready_wait", {31'b0, bus.ready_o}, 32'd1);
    bus.op_i    = op;
    bus.rm_i    = rm;
    bus.valid_i = 1'b1;
    bus.ready_i = (hold == 0);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 0;
    while (!bus.valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result_o;
    inv = bus.invalid_o;
    inx = bus.inexact_o;
    repeat (hold) @(posedge clk);
    #1 bus.ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er;
    logic        iv, ix, eiv, eix;
    int          l, el, w;
    logic [15:0] op;
    logic        rm;

    tbl[0]  = '{16'h42F7, 1'b1, 32'h0000_007C, 1'b0, 1'b1, 3};
    tbl[1]  = '{16'h42F7, 1'b0, 32'h0000_007B, 1'b0, 1'b1, 3};
    tbl[2]  = '{16'hBFC0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 9};
    tbl[3]  = '{16'hBFC0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 9};
    tbl[4]  = '{16'h4B80, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 19};
    tbl[5]  = '{16'hCF00, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1};
    tbl[6]  = '{16'h4F00, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
    tbl[7]  = '{16'h7FC0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
    tbl[8]  = '{16'hFF80, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1};
    tbl[9]  = '{16'h3F00, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1};
    tbl[10] = '{16'h3F40, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1};
    tbl[11] = '{16'h8000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1};
    tbl[12] = '{16'h3F80, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 9};
    tbl[13] = '{16'h4300, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 2};
    tbl[14] = '{16'h4EFF, 1'b0, 32'h7F80_0000, 1'b0, 1'b0, 25};
    tbl[15] = '{16'hBF40, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1};
    tbl[16] = '{16'h0001, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1};

    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.op_i    = '0;
    bus.rm_i    = 1'b0;
    bus.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, bus.ready_o}, 32'd1);
    chk("reset_valid", {31'b0, bus.valid_o}, 32'd0);
    chk("reset_result", bus.result_o, 32'd0);
    chk("reset_flags", {30'b0, bus.invalid_o, bus.inexact_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      run(tbl[i].op, tbl[i].rm, 0, r, iv, ix, l);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
      chk($sformatf("tbl%0d_invalid", i), {31'b0, iv}, {31'b0, tbl[i].inv});
      chk($sformatf("tbl%0d_inexact", i), {31'b0, ix}, {31'b0, tbl[i].inx});
      chk($sformatf("tbl%0d_latency", i), l, tbl[i].lat);
    end

    // Output stall: result held, no new acceptance, a stray valid_i pulse is ignored.
    @(negedge clk);
    bus.op_i = 16'h42F7; bus.rm_i = 1'b1; bus.valid_i = 1'b1; bus.ready_i = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    chk("stall_ready_fall", {31'b0, bus.ready_o}, 32'd0);
    w = 0;
    while (!bus.valid_o && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("stall_latency", w, 3);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin bus.op_i = 16'h3F80; bus.rm_i = 1'b0; bus.valid_i = 1'b1; end
      if (i == 2) bus.valid_i = 1'b0;
      @(posedge clk); #1;
      chk("stall_result", bus.result_o, 32'h0000_007C);
      chk("stall_valid", {31'b0, bus.valid_o}, 32'd1);
      chk("stall_ready", {31'b0, bus.ready_o}, 32'd0);
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", {31'b0, bus.valid_o}, 32'd0);
    chk("stall_release_ready", {31'b0, bus.ready_o}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_no_phantom", {31'b0, bus.valid_o}, 32'd0);

    // Reset while shifting 2^24.
    @(negedge clk);
    bus.op_i = 16'h4B80; bus.rm_i = 1'b1; bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, bus.valid_o}, 32'd0);
    chk("midrst_ready", {31'b0, bus.ready_o}, 32'd1);
    chk("midrst_result", bus.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(16'h42F7, 1'b1, 0, r, iv, ix, l);
    chk("postrst_result", r, 32'h0000_007C);
    chk("postrst_inexact", {31'b0, ix}, 32'd1);
    chk("postrst_latency", l, 3);

    // Random operands against the value model, with random downstream stalls.
    for (int n = 0; n < 400; n++) begin
      op = 16'($urandom);
      if ($urandom_range(0, 3) != 0) op[14:7] = 8'($urandom_range(115, 162));
      rm = 1'($urandom);
      model(op, rm, er, eiv, eix, el);
      run(op, rm, int'($urandom_range(0, 2)), r, iv, ix, l);
      chk($sformatf("rnd_%h_%0d_result", op, rm), r, er);
      chk($sformatf("rnd_%h_%0d_invalid", op, rm), {31'b0, iv}, {31'b0, eiv});
      chk($sformatf("rnd_%h_%0d_inexact", op, rm), {31'b0, ix}, {31'b0, eix});
      chk($sformatf("rnd_%h_%0d_latency", op, rm), l, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
    $finish;
  end

endmodule
